// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory bus
// One outstanding transaction; data has priority, bounded by a fetch starvation limit.
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_sel,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          drop;
  logic          owner_data;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_sel;

  logic inst_elig;
  logic starved;
  logic inst_win;
  logic data_win;
  logic resp_done;
  logic inst_busy;
  logic data_busy;

  // A flush in IDLE hides the fetch request but leaves data selection alone.
  assign inst_elig = inst_req & ~flush;
  assign starved   = (starve_cnt == LIMIT_C);
  assign inst_win  = (state == IDLE) & inst_elig & (~data_req | starved);
  assign data_win  = (state == IDLE) & data_req & ~inst_win;
  assign resp_done = (state == RESP) & bus_rvalid;
  assign inst_busy = (state != IDLE) & ~owner_data;
  assign data_busy = (state != IDLE) & owner_data;

  assign inst_gnt    = rst & inst_win;
  assign data_gnt    = rst & data_win;
  assign inst_rvalid = rst & resp_done & ~owner_data & ~drop & ~flush;
  assign data_rvalid = rst & resp_done & owner_data;
  assign inst_rdata  = inst_rvalid ? bus_rdata : 32'h0;
  assign data_rdata  = data_rvalid ? bus_rdata : 32'h0;

  assign bus_req   = (state == ADDR);
  assign bus_we    = lat_we;
  assign bus_addr  = lat_addr;
  assign bus_wdata = lat_wdata;
  assign bus_sel   = lat_sel;

  assign stall_if  = rst & ~drop & (inst_req | inst_busy) & ~inst_rvalid;
  assign stall_mem = rst & (data_req | data_busy) & ~data_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      owner_data <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_sel    <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          drop <= 1'b0;
          if (inst_win) begin
            owner_data <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= inst_addr;
            lat_wdata  <= 32'h0;
            lat_sel    <= 4'hF;
            starve_cnt <= '0;
            state      <= ADDR;
          end else if (data_win) begin
            owner_data <= 1'b1;
            lat_we     <= data_we;
            lat_addr   <= data_addr;
            lat_wdata  <= data_wdata;
            lat_sel    <= data_sel;
            if (!inst_elig)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + CW'(1);
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (flush && !owner_data)
            drop <= 1'b1;
          if (bus_gnt)
            state <= RESP;
        end
        RESP: begin
          if (bus_rvalid) begin
            drop  <= 1'b0;
            state <= IDLE;
          end else if (flush && !owner_data) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
